// File: rtl/snow64_bfloat16_add_pkg.sv
// PkgSnow64BFloat16: BFloat16 format constants, port structs and the adder FSM state type.
package PkgSnow64BFloat16;

    localparam int unsigned BF16_WIDTH = 16;
    localparam int unsigned EXP_WIDTH  = 8;
    localparam int unsigned MANT_WIDTH = 7;
    localparam int unsigned EXP_BIAS   = 127;

    localparam logic [EXP_WIDTH-1:0]  EXP_SPECIAL = 8'hFF;
    localparam logic [BF16_WIDTH-1:0] QNAN        = 16'h7FC0;
    localparam logic [BF16_WIDTH-2:0] SAT_MAG     = 15'h7F7F;

    typedef struct packed {
        logic                  sign;
        logic [EXP_WIDTH-1:0]  enc_exp;
        logic [MANT_WIDTH-1:0] enc_mantissa;
    } BFloat16;

    typedef struct packed {
        logic                  start;
        logic [BF16_WIDTH-1:0] a;
        logic [BF16_WIDTH-1:0] b;
    } PortIn_BinOp;

    typedef struct packed {
        logic                  can_accept_cmd;
        logic                  data_valid;
        logic [BF16_WIDTH-1:0] data;
    } PortOut_BinOp;

    typedef enum logic [1:0] {
        StIdle,
        StAlign,
        StAdd,
        StNorm
    } StateAdd;

endpackage

// File: rtl/snow64_count_leading_zeros_16.sv
// snow64_count_leading_zeros_16: combinational leading-zero count of a 16-bit word (16 when zero).
module snow64_count_leading_zeros_16 (
    input  logic [15:0] data,
    output logic [4:0]  count
);

    logic found;

    // Scan from the MSB; the first set bit fixes the count.
    always_comb begin
        count = 5'd16;
        found = 1'b0;
        for (int unsigned i = 0; i < 16; i++) begin
            if (!found && data[15 - i]) begin
                count = 5'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/snow64_bfloat16_add.sv
// snow64_bfloat16_add: multi-cycle BFloat16 adder (IDLE->ALIGN->ADD->NORM), one op in flight.
// Optional: define SNOW64_BFLOAT16_ADD_SPECIALS_EN to treat exp=255 as inf/NaN and overflow to inf;
// otherwise exp=255 is an ordinary exponent and overflow saturates to +/-7F7F.
module snow64_bfloat16_add
    import PkgSnow64BFloat16::*;
(
    input  logic         clk,
    input  logic         rst,
    input  PortIn_BinOp  in,
    output PortOut_BinOp out
);

    StateAdd state, next_state;

    BFloat16 op_a, op_b;

    // ALIGN -> ADD pipeline registers
    logic [15:0] sig_big, sig_small;
    logic [7:0]  exp_big;
    logic        sign_big, do_sub;

    // ADD -> NORM register
    logic [16:0] sum;

    logic [15:0] data_r;
    logic        data_valid_r;

    // ALIGN combinational terms
    BFloat16     big_c, small_c;
    logic [15:0] sig_big_c, sig_small_full_c, sig_small_c;
    logic [7:0]  exp_diff_c;

    // NORM combinational terms
    logic [4:0]        lz;
    logic [15:0]       shifted_c;
    logic signed [9:0] exp_norm_c;
    logic [6:0]        mant_c;
    logic [15:0]       result_c;

    logic start_accepted;
    assign start_accepted = in.start && (state == StIdle);

`ifdef SNOW64_BFLOAT16_ADD_SPECIALS_EN
    logic        a_nan, b_nan, a_inf, b_inf;
    logic        special_c, special_r;
    logic [15:0] special_data_c, special_data_r;

    // Resolve inf/NaN operands up front; they bypass the arithmetic path.
    always_comb begin
        a_nan = (op_a.enc_exp == EXP_SPECIAL) && (op_a.enc_mantissa != '0);
        b_nan = (op_b.enc_exp == EXP_SPECIAL) && (op_b.enc_mantissa != '0);
        a_inf = (op_a.enc_exp == EXP_SPECIAL) && (op_a.enc_mantissa == '0);
        b_inf = (op_b.enc_exp == EXP_SPECIAL) && (op_b.enc_mantissa == '0);
        special_c      = 1'b1;
        special_data_c = '0;
        if (a_nan || b_nan || (a_inf && b_inf && (op_a.sign != op_b.sign))) begin
            special_data_c = QNAN;
        end else if (a_inf) begin
            special_data_c = op_a;
        end else if (b_inf) begin
            special_data_c = op_b;
        end else begin
            special_c = 1'b0;
        end
    end
`endif

    // Pick the larger-magnitude operand and align the smaller one to its exponent.
    always_comb begin
        if ({op_a.enc_exp, op_a.enc_mantissa} >= {op_b.enc_exp, op_b.enc_mantissa}) begin
            big_c   = op_a;
            small_c = op_b;
        end else begin
            big_c   = op_b;
            small_c = op_a;
        end
        sig_big_c        = (big_c.enc_exp == '0)   ? '0 : {1'b1, big_c.enc_mantissa, 8'h00};
        sig_small_full_c = (small_c.enc_exp == '0) ? '0 : {1'b1, small_c.enc_mantissa, 8'h00};
        exp_diff_c       = big_c.enc_exp - small_c.enc_exp;
        sig_small_c      = (exp_diff_c >= 8'd16) ? '0 : (sig_small_full_c >> exp_diff_c[3:0]);
    end

    snow64_count_leading_zeros_16 u_lzc (
        .data  (sum[15:0]),
        .count (lz)
    );

    // Normalise the raw sum, truncate the mantissa and clamp the exponent range.
    always_comb begin
        shifted_c = sum[15:0] << lz;
        if (sum[16]) begin
            mant_c     = 7'(sum >> 9);
            exp_norm_c = $signed({2'b00, exp_big}) + 10'sd1;
        end else begin
            mant_c     = 7'(shifted_c >> 8);
            exp_norm_c = $signed({2'b00, exp_big}) - $signed({5'b00000, lz});
        end
        if (sum == '0) begin
            result_c = '0;
        end else if (exp_norm_c <= 10'sd0) begin
            result_c = {sign_big, 15'h0000};
        end else if (exp_norm_c >= 10'sd255) begin
`ifdef SNOW64_BFLOAT16_ADD_SPECIALS_EN
            result_c = {sign_big, EXP_SPECIAL, 7'h00};
`else
            result_c = {sign_big, SAT_MAG};
`endif
        end else begin
            result_c = {sign_big, exp_norm_c[7:0], mant_c};
        end
`ifdef SNOW64_BFLOAT16_ADD_SPECIALS_EN
        if (special_r) begin
            result_c = special_data_r;
        end
`endif
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one cycle per stage, starts while busy are dropped.
    always_comb begin
        next_state = StIdle;
        unique case (state)
            StIdle:  next_state = in.start ? StAlign : StIdle;
            StAlign: next_state = StAdd;
            StAdd:   next_state = StNorm;
            StNorm:  next_state = StIdle;
            default: next_state = StIdle;
        endcase
    end

    // Output drive: idle doubles as the result cycle, so a new start is taken alongside data_valid.
    always_comb begin
        out.can_accept_cmd = (state == StIdle);
        out.data_valid     = data_valid_r;
        out.data           = data_r;
    end

    // Operand latch and per-stage datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a      <= '0;
            op_b      <= '0;
            sig_big   <= '0;
            sig_small <= '0;
            exp_big   <= '0;
            sign_big  <= 1'b0;
            do_sub    <= 1'b0;
            sum       <= '0;
`ifdef SNOW64_BFLOAT16_ADD_SPECIALS_EN
            special_r      <= 1'b0;
            special_data_r <= '0;
`endif
        end else begin
            if (start_accepted) begin
                op_a <= in.a;
                op_b <= in.b;
            end
            if (state == StAlign) begin
                sig_big   <= sig_big_c;
                sig_small <= sig_small_c;
                exp_big   <= big_c.enc_exp;
                sign_big  <= big_c.sign;
                do_sub    <= big_c.sign ^ small_c.sign;
`ifdef SNOW64_BFLOAT16_ADD_SPECIALS_EN
                special_r      <= special_c;
                special_data_r <= special_data_c;
`endif
            end
            if (state == StAdd) begin
                sum <= do_sub ? ({1'b0, sig_big} - {1'b0, sig_small})
                              : ({1'b0, sig_big} + {1'b0, sig_small});
            end
        end
    end

    // Result register and single-cycle valid pulse on leaving NORM.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_r       <= '0;
            data_valid_r <= 1'b0;
        end else begin
            data_valid_r <= (state == StNorm);
            if (state == StNorm) begin
                data_r <= result_c;
            end
        end
    end

endmodule

// File: tb/tb_snow64_bfloat16_add.sv
// tb_snow64_bfloat16_add: scoreboard bench for the BFloat16 adder with an arithmetic reference model.
module tb_snow64_bfloat16_add;
    import PkgSnow64BFloat16::*;

    logic         clk = 1'b0;
    logic         rst;
    PortIn_BinOp  in_s;
    PortOut_BinOp out_s;

    int vectors     = 0;
    int miscompares = 0;

    // Cycles since the last accepted start (saturates at 100 = idle).
    int          since = 100;
    logic [15:0] exp_q[$];
    logic [15:0] exp_data = '0;
    logic        use_const = 1'b0;
    logic [15:0] const_exp = '0;

    snow64_bfloat16_add dut (
        .clk (clk),
        .rst (rst),
        .in  (in_s),
        .out (out_s)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        int     ex, ey, mx, my, e_big, e_small, m_big, m_small, d, k, e_res, mant;
        logic   sx, sy, s_big, s_small;
        longint sig_big, sig_small, r;
        sx = x[15]; ex = int'(x[14:7]); mx = int'(x[6:0]);
        sy = y[15]; ey = int'(y[14:7]); my = int'(y[6:0]);
`ifdef SNOW64_BFLOAT16_ADD_SPECIALS_EN
        if ((ex == 255 && mx != 0) || (ey == 255 && my != 0)) return 16'h7FC0;
        if (ex == 255 && ey == 255 && sx != sy) return 16'h7FC0;
        if (ex == 255) return x;
        if (ey == 255) return y;
`endif
        if (ex * 128 + mx >= ey * 128 + my) begin
            e_big = ex; m_big = mx; s_big = sx; e_small = ey; m_small = my; s_small = sy;
        end else begin
            e_big = ey; m_big = my; s_big = sy; e_small = ex; m_small = mx; s_small = sx;
        end
        sig_big   = (e_big == 0)   ? 0 : longint'((128 + m_big) * 256);
        sig_small = (e_small == 0) ? 0 : longint'((128 + m_small) * 256);
        d = e_big - e_small;
        sig_small = (d >= 16) ? 0 : sig_small / (longint'(1) << d);
        r = (s_big == s_small) ? sig_big + sig_small : sig_big - sig_small;
        if (r == 0) return 16'h0000;
        k = 0;
        while ((r >> (k + 1)) != 0) k++;
        e_res = e_big + k - 15;
        mant  = (k >= 7) ? int'((r >> (k - 7)) & 127) : int'((r << (7 - k)) & 127);
        if (e_res <= 0) return {s_big, 15'h0000};
`ifdef SNOW64_BFLOAT16_ADD_SPECIALS_EN
        if (e_res >= 255) return {s_big, 8'hFF, 7'h00};
`else
        if (e_res >= 255) return {s_big, 15'h7F7F};
`endif
        return {s_big, e_res[7:0], mant[6:0]};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Handshake model: decides acceptance and pushes the expected result.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            since = 100;
            exp_q.delete();
        end else if (in_s.start && since >= 3) begin
            since = 0;
            exp_q.push_back(use_const ? const_exp : ref_add(in_s.a, in_s.b));
        end else if (since < 100) begin
            since++;
        end
    end

    // Monitor: pops on the result cycle and checks every output every cycle.
    always @(negedge clk) begin
        if (rst) begin
            exp_data = '0;
        end else if (since == 3) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL scoreboard_empty: got result cycle, expected no pending op (t=%0t)", $time);
            end else begin
                exp_data = exp_q.pop_front();
            end
        end
        check("can_accept_cmd", 16'(out_s.can_accept_cmd), 16'(since >= 3));
        check("data_valid", 16'(out_s.data_valid), 16'(since == 3));
        check("data", out_s.data, exp_data);
    end

    task automatic wait_accept();
        int n = 0;
        do begin
            @(posedge clk); #2;
            n++;
        end while (since != 0 && n < 20);
        if (since != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL accept_timeout: got no accept, expected accept within 20 cycles");
        end
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input logic uc, input logic [15:0] c);
        in_s.a = a; in_s.b = b; use_const = uc; const_exp = c;
        in_s.start = 1'b1;
        wait_accept();
        in_s.start = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        logic [15:0] ra, rb;
        in_s = '0;
        rst  = 1'b1;
        idle(3);
        rst = 1'b0;
        idle(2);

        // Basic op while a second request is held during the busy cycles.
        in_s.a = 16'h3F80; in_s.b = 16'h3F80; use_const = 1'b1; const_exp = 16'h4000;
        in_s.start = 1'b1;
        wait_accept();
        in_s.a = 16'h4040; in_s.b = 16'h4040;
        idle(2);
        in_s.start = 1'b0;
        idle(4);

        issue(16'h3FC0, 16'h3E80, 1'b1, 16'h3FE0);
        issue(16'h4040, 16'hBF80, 1'b1, 16'h4000);
        issue(16'h3F80, 16'hBF80, 1'b1, 16'h0000);
        issue(16'h4780, 16'h3F80, 1'b1, 16'h4780);
        issue(16'h0000, 16'hBF80, 1'b1, 16'hBF80);
`ifdef SNOW64_BFLOAT16_ADD_SPECIALS_EN
        issue(16'h7F7F, 16'h7F7F, 1'b1, 16'h7F80);
        issue(16'h7FC0, 16'h3F80, 1'b1, 16'h7FC0);
        issue(16'h7F80, 16'hFF80, 1'b1, 16'h7FC0);
`else
        issue(16'h7F7F, 16'h7F7F, 1'b1, 16'h7F7F);
`endif
        idle(5);

        // Reset during ALIGN aborts the op with no later valid pulse.
        issue(16'h3FC0, 16'h3E80, 1'b1, 16'h3FE0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        idle(6);

        // Back-to-back with start held high.
        in_s.start = 1'b1;
        use_const = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_s.a = 16'($urandom);
            in_s.b = 16'($urandom);
            wait_accept();
        end
        in_s.start = 1'b0;
        idle(5);

        // Random operands, biased toward nearby exponents and zeros.
        for (int i = 0; i < 300; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rb[14:7] = ra[14:7] - 8'($urandom_range(0, 3));
                1: rb[14:7] = ra[14:7];
                2: rb[14:7] = 8'h00;
                default: ;
            endcase
            issue(ra, rb, 1'b0, 16'h0000);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 6));
        end
        idle(8);

        check("scoreboard_drained", 16'(exp_q.size()), 16'h0000);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
